// File: rtl/memory.sv
// rtl/memory.sv - memory-access pipeline stage with data-bus handshake; MEMORY_WAIT_EN enables bus wait states
module memory (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write_e,
  input  logic        rd_write_e,
  input  logic [1:0]  rd_write_src_e,
  input  logic        mem_write_e,
  input  logic [4:0]  rd_e,
  input  logic [31:0] pc_e,
  input  logic [31:0] alu_res_e,
  input  logic [31:0] mem_data_e,
  input  logic [31:0] csr_data_e,
  output logic        pc_write_m,
  output logic        rd_write_m,
  output logic [1:0]  rd_write_src_m,
  output logic [4:0]  rd_m,
  output logic [31:0] pc_m,
  output logic [31:0] alu_res_m,
  output logic [31:0] csr_data_m,
  output logic [31:0] mem_rdata_m,
  input  logic        stall_m,
  input  logic        flush_m,
  output logic        mem_busy_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic        pc_write_q, rd_write_q, mem_write_q;
  logic [1:0]  rd_write_src_q;
  logic [4:0]  rd_q;
  logic [31:0] pc_q, alu_res_q, mem_data_q, csr_data_q;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic        flushed_q, flushed_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_op, stage_load, ready, capture;

  assign stage_load = flush_m | ~stall_m;
  assign mem_op     = mem_write_q | (rd_write_q & (rd_write_src_q == 2'b01));

`ifdef MEMORY_WAIT_EN
  assign ready      = dmem_ready;
  assign mem_busy_m = dmem_req & ~dmem_ready;
`else
  // Without wait states every access is treated as finished in its issue cycle.
  logic unused_dmem_ready;
  assign unused_dmem_ready = dmem_ready;
  assign ready             = 1'b1;
  assign mem_busy_m        = 1'b0;
`endif

  assign pc_write_m     = pc_write_q;
  assign rd_write_m     = rd_write_q;
  assign rd_write_src_m = rd_write_src_q;
  assign rd_m           = rd_q;
  assign pc_m           = pc_q;
  assign alu_res_m      = alu_res_q;
  assign csr_data_m     = csr_data_q;
  assign mem_rdata_m    = capture ? dmem_rdata : rdata_q;

  // Stage registers: flush clears, otherwise load unless stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_write_q     <= 1'b0;
      rd_write_q     <= 1'b0;
      rd_write_src_q <= 2'b00;
      mem_write_q    <= 1'b0;
      rd_q           <= 5'd0;
      pc_q           <= 32'd0;
      alu_res_q      <= 32'd0;
      mem_data_q     <= 32'd0;
      csr_data_q     <= 32'd0;
    end else if (flush_m) begin
      pc_write_q     <= 1'b0;
      rd_write_q     <= 1'b0;
      rd_write_src_q <= 2'b00;
      mem_write_q    <= 1'b0;
      rd_q           <= 5'd0;
      pc_q           <= 32'd0;
      alu_res_q      <= 32'd0;
      mem_data_q     <= 32'd0;
      csr_data_q     <= 32'd0;
    end else if (!stall_m) begin
      pc_write_q     <= pc_write_e;
      rd_write_q     <= rd_write_e;
      rd_write_src_q <= rd_write_src_e;
      mem_write_q    <= mem_write_e;
      rd_q           <= rd_e;
      pc_q           <= pc_e;
      alu_res_q      <= alu_res_e;
      mem_data_q     <= mem_data_e;
      csr_data_q     <= csr_data_e;
    end
  end

  // Bus FSM state, bus-side latches and captured load data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      flushed_q   <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      flushed_q   <= flushed_d;
      rdata_q     <= rdata_d;
    end
  end

  // Issue, wait and hold sequencing; completing while the stage loads skips HOLD so the next op is not lost.
  always_comb begin
    state_d     = state_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    flushed_d   = flushed_q;
    rdata_d     = rdata_q;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    dmem_addr   = 32'd0;
    dmem_wdata  = 32'd0;
    capture     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          dmem_req   = 1'b1;
          dmem_we    = mem_write_q;
          dmem_addr  = alu_res_q;
          dmem_wdata = mem_data_q;
          if (ready) begin
            capture = ~mem_write_q & ~flush_m;
            state_d = stage_load ? S_IDLE : S_HOLD;
          end
`ifdef MEMORY_WAIT_EN
          else begin
            state_d     = S_WAIT;
            bus_we_d    = mem_write_q;
            bus_addr_d  = alu_res_q;
            bus_wdata_d = mem_data_q;
            flushed_d   = flush_m;
          end
`endif
        end
      end
`ifdef MEMORY_WAIT_EN
      S_WAIT: begin
        dmem_req   = 1'b1;
        dmem_we    = bus_we_q;
        dmem_addr  = bus_addr_q;
        dmem_wdata = bus_wdata_q;
        if (ready) begin
          capture   = ~bus_we_q & ~flushed_q & ~flush_m;
          state_d   = (flushed_q | flush_m | stage_load) ? S_IDLE : S_HOLD;
          flushed_d = 1'b0;
        end else begin
          flushed_d = flushed_q | flush_m;
        end
      end
`endif
      S_HOLD: begin
        if (stage_load) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (capture) rdata_d = dmem_rdata;
  end

endmodule

// File: tb/tb_memory.sv
// tb/tb_memory.sv - randomized self-checking bench for memory against a transaction-level model
`timescale 1ns/1ps
module tb_memory;

`ifdef MEMORY_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write_e, rd_write_e, mem_write_e;
  logic [1:0]  rd_write_src_e;
  logic [4:0]  rd_e;
  logic [31:0] pc_e, alu_res_e, mem_data_e, csr_data_e;
  logic        pc_write_m, rd_write_m;
  logic [1:0]  rd_write_src_m;
  logic [4:0]  rd_m;
  logic [31:0] pc_m, alu_res_m, csr_data_m, mem_rdata_m;
  logic        stall_m, flush_m, mem_busy_m, stall_r;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;

  always #5 clk = ~clk;

  memory dut (
    .clk(clk), .rst_n(rst_n),
    .pc_write_e(pc_write_e), .rd_write_e(rd_write_e), .rd_write_src_e(rd_write_src_e),
    .mem_write_e(mem_write_e), .rd_e(rd_e), .pc_e(pc_e), .alu_res_e(alu_res_e),
    .mem_data_e(mem_data_e), .csr_data_e(csr_data_e),
    .pc_write_m(pc_write_m), .rd_write_m(rd_write_m), .rd_write_src_m(rd_write_src_m),
    .rd_m(rd_m), .pc_m(pc_m), .alu_res_m(alu_res_m), .csr_data_m(csr_data_m),
    .mem_rdata_m(mem_rdata_m), .stall_m(stall_m), .flush_m(flush_m), .mem_busy_m(mem_busy_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
  );

  typedef struct packed {
    logic        pc_write;
    logic        rd_write;
    logic [1:0]  src;
    logic        mem_write;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] mdata;
    logic [31:0] csr;
  } stage_t;

  // Model: stage contents, whether its access is already serviced, and any outstanding bus transaction.
  stage_t      m_st;
  logic        served, oa, o_we, o_disc;
  logic [31:0] o_addr, o_wdata, m_rdata;
  logic        e_req, e_we, e_busy, e_done, e_disc, e_cap;
  logic [31:0] e_addr, e_wdata, e_rdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = '0; served = 1'b0; oa = 1'b0; o_we = 1'b0; o_disc = 1'b0;
    o_addr = '0; o_wdata = '0; m_rdata = '0;
  endtask

  task automatic model_comb();
    logic is_mem, rdy;
    rdy    = WAIT_EN ? dmem_ready : 1'b1;
    is_mem = m_st.mem_write || (m_st.rd_write && m_st.src == 2'd1);
    e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_disc = 1'b0;
    if (oa) begin
      e_req = 1'b1; e_we = o_we; e_addr = o_addr; e_wdata = o_wdata; e_disc = o_disc || flush_m;
    end else if (is_mem && !served) begin
      e_req = 1'b1; e_we = m_st.mem_write; e_addr = m_st.alu; e_wdata = m_st.mdata; e_disc = flush_m;
    end
    e_done  = e_req && rdy;
    e_busy  = e_req && !rdy;
    e_cap   = e_done && !e_we && !e_disc;
    e_rdata = e_cap ? dmem_rdata : m_rdata;
  endtask

  // Called at a falling edge with inputs set: drive stall, then compare every output.
  task automatic eval();
    model_comb();
    stall_m = stall_r || e_busy;
    #1;
    chk("pc_write_m", pc_write_m, m_st.pc_write);
    chk("rd_write_m", rd_write_m, m_st.rd_write);
    chk("rd_write_src_m", rd_write_src_m, m_st.src);
    chk("rd_m", rd_m, m_st.rd);
    chk("pc_m", pc_m, m_st.pc);
    chk("alu_res_m", alu_res_m, m_st.alu);
    chk("csr_data_m", csr_data_m, m_st.csr);
    chk("dmem_req", dmem_req, e_req);
    chk("dmem_we", dmem_we, e_we);
    chk("dmem_addr", dmem_addr, e_addr);
    chk("dmem_wdata", dmem_wdata, e_wdata);
    chk("mem_busy_m", mem_busy_m, e_busy);
    chk("mem_rdata_m", mem_rdata_m, e_rdata);
  endtask

  task automatic tick();
    logic load;
    @(posedge clk);
    load = flush_m || !stall_m;
    if (e_cap) m_rdata = dmem_rdata;
    served = load ? 1'b0 : (served || e_req);
    if (e_req && !e_done) begin
      oa = 1'b1; o_we = e_we; o_addr = e_addr; o_wdata = e_wdata; o_disc = e_disc;
    end else begin
      oa = 1'b0;
    end
    if (flush_m) begin
      m_st = '0;
    end else if (!stall_m) begin
      m_st.pc_write = pc_write_e; m_st.rd_write = rd_write_e; m_st.src = rd_write_src_e;
      m_st.mem_write = mem_write_e; m_st.rd = rd_e; m_st.pc = pc_e; m_st.alu = alu_res_e;
      m_st.mdata = mem_data_e; m_st.csr = csr_data_e;
    end
    @(negedge clk);
  endtask

  task automatic set_nop();
    pc_write_e = 0; rd_write_e = 0; rd_write_src_e = 0; mem_write_e = 0; rd_e = 0;
    pc_e = 0; alu_res_e = 0; mem_data_e = 0; csr_data_e = 0;
    flush_m = 0; stall_r = 0; dmem_ready = 1; dmem_rdata = 0;
  endtask

  task automatic rand_inputs();
    int k;
    k = $urandom_range(0, 3);
    pc_write_e = 1'($urandom); rd_e = 5'($urandom); pc_e = $urandom;
    alu_res_e = $urandom; mem_data_e = $urandom; csr_data_e = $urandom;
    case (k)
      0: begin mem_write_e = 1; rd_write_e = 0; rd_write_src_e = 2'($urandom); end
      1: begin mem_write_e = 0; rd_write_e = 1; rd_write_src_e = 2'd1; end
      2: begin mem_write_e = 0; rd_write_e = 1; rd_write_src_e = ($urandom_range(0, 1) != 0) ? 2'd0 : 2'd2; end
      default: begin mem_write_e = 1'($urandom); rd_write_e = 1'($urandom); rd_write_src_e = 2'($urandom); end
    endcase
    flush_m    = ($urandom_range(0, 99) < 8);
    stall_r    = ($urandom_range(0, 99) < 30);
    dmem_ready = 1'($urandom);
    dmem_rdata = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    set_nop();
    stall_m = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", dmem_req, 0);
    chk("rst_busy", mem_busy_m, 0);
    chk("rst_rdata", mem_rdata_m, 0);
    chk("rst_pc", pc_m, 0);
    rst_n = 1;

    // Store with immediate ready: one request cycle.
    set_nop(); mem_write_e = 1; alu_res_e = 32'h100; mem_data_e = 32'hDEADBEEF;
    eval(); tick();
    set_nop(); eval();
    chk("st_req", dmem_req, 1); chk("st_we", dmem_we, 1);
    chk("st_addr", dmem_addr, 32'h100); chk("st_wdata", dmem_wdata, 32'hDEADBEEF);
    chk("st_busy", mem_busy_m, 0);
    tick();
    eval(); chk("st_req_end", dmem_req, 0); tick();

    // Store completes, then 4 stalled cycles: exactly one request pulse.
    set_nop(); mem_write_e = 1; alu_res_e = 32'h300; mem_data_e = 32'h0BADF00D;
    eval(); tick();
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      set_nop(); stall_r = 1; eval(); pulses += int'(dmem_req); tick();
    end
    set_nop(); eval(); pulses += int'(dmem_req); tick();
    chk("stall_pulses", 32'(pulses), 1);

`ifdef MEMORY_WAIT_EN
    // Load with three wait cycles.
    set_nop(); rd_write_e = 1; rd_write_src_e = 2'b01; alu_res_e = 32'h200;
    eval(); tick();
    for (int i = 0; i < 3; i++) begin
      set_nop(); dmem_ready = 0; dmem_rdata = $urandom; eval();
      chk("ld_wait_busy", mem_busy_m, 1); chk("ld_wait_addr", dmem_addr, 32'h200);
      tick();
    end
    set_nop(); dmem_rdata = 32'h12345678; eval();
    chk("ld_ready_busy", mem_busy_m, 0); chk("ld_ready_rdata", mem_rdata_m, 32'h12345678);
    tick();
    set_nop(); dmem_ready = 0; eval();
    chk("ld_after_rdata", mem_rdata_m, 32'h12345678); chk("ld_after_req", dmem_req, 0);
    tick();

    // Flush during WAIT: stage clears, bus completes, data discarded.
    set_nop(); rd_write_e = 1; rd_write_src_e = 2'b01; rd_e = 5'd7; alu_res_e = 32'h240;
    eval(); tick();
    set_nop(); dmem_ready = 0; eval(); tick();
    set_nop(); dmem_ready = 0; flush_m = 1; eval(); tick();
    set_nop(); dmem_ready = 0; eval();
    chk("fl_alu", alu_res_m, 0); chk("fl_rdw", rd_write_m, 0); chk("fl_rd", rd_m, 0);
    chk("fl_req", dmem_req, 1); chk("fl_addr", dmem_addr, 32'h240);
    tick();
    set_nop(); dmem_rdata = 32'hFFFF0000; eval();
    chk("fl_ready_req", dmem_req, 1); chk("fl_ready_rdata", mem_rdata_m, 32'h12345678);
    tick();
    set_nop(); eval();
    chk("fl_done_req", dmem_req, 0); chk("fl_done_rdata", mem_rdata_m, 32'h12345678);
    tick();
`else
    // Load with dmem_ready low still completes in its issue cycle.
    set_nop(); rd_write_e = 1; rd_write_src_e = 2'b01; alu_res_e = 32'h200;
    eval(); tick();
    set_nop(); dmem_ready = 0; dmem_rdata = 32'hCAFE0001; eval();
    chk("nw_req", dmem_req, 1); chk("nw_we", dmem_we, 0);
    chk("nw_busy", mem_busy_m, 0); chk("nw_rdata", mem_rdata_m, 32'hCAFE0001);
    tick();
    set_nop(); dmem_ready = 0; eval();
    chk("nw_req_end", dmem_req, 0); chk("nw_rdata_held", mem_rdata_m, 32'hCAFE0001);
    tick();
`endif

    // Reset in the middle of an access.
    set_nop(); rd_write_e = 1; rd_write_src_e = 2'b01; rd_e = 5'd3; alu_res_e = 32'h280;
    eval(); tick();
    set_nop(); stall_r = 1; dmem_ready = 0; eval(); tick();
    set_nop(); stall_r = 1; dmem_ready = 0;
    rst_n = 0;
    #1;
    chk("rstm_req", dmem_req, 0); chk("rstm_busy", mem_busy_m, 0);
    chk("rstm_rdw", rd_write_m, 0); chk("rstm_alu", alu_res_m, 0);
    chk("rstm_rd", rd_m, 0); chk("rstm_rdata", mem_rdata_m, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;

    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      eval();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
REQ-002 The module SHALL receive these inputs from the execute stage:
- pc_write_e  in  1  branch/jump writes PC.
- rd_write_e  in  1  instruction writes rd.
- rd_write_src_e  in  2  writeback source: 00 ALU, 01 MEM, 10 PC+4, 11 CSR.
- mem_write_e  in  1  store.
- rd_e  in  5  destination register.
- pc_e  in  32  instruction PC.
- alu_res_e  in  32  ALU result / effective address.
- mem_data_e  in  32  store data.
- csr_data_e  in  32  CSR read data.
REQ-003 The module SHALL drive these outputs to writeback:
- pc_write_m, rd_write_m, rd_write_src_m[1:0], rd_m[4:0], pc_m[31:0], alu_res_m[31:0], csr_data_m[31:0]  out  registered copies of the _e inputs.
- mem_rdata_m  out  32  load data.
REQ-004 The module SHALL have these hazard-unit ports:
- stall_m  in  1  hold stage registers.
- flush_m  in  1  clear stage registers.
- mem_busy_m  out  1  access pending; the hazard unit stalls all stages.
REQ-005 The module SHALL have these data-memory bus ports:
- dmem_req  out  1  access request.
- dmem_we  out  1  write.
- dmem_addr  out  32  word address.
- dmem_wdata  out  32  write data.
- dmem_ready  in  1  access complete.
- dmem_rdata  in  32  read data, valid with dmem_ready.

Function
REQ-006 On each rising edge, flush_m (priority) SHALL clear all stage registers, else !stall_m SHALL load every _e input into its _m register, else the registers SHALL hold.
REQ-007 The registered instruction SHALL be a memory operation when mem_write_m=1 (store) or rd_write_m=1 with rd_write_src_m=01 (load).
REQ-008 The FSM SHALL have three states: IDLE, WAIT, HOLD; reset state IDLE.
REQ-009 In IDLE with a memory operation registered, the module SHALL assert dmem_req and drive dmem_we=mem_write_m, dmem_addr=alu_res_m, dmem_wdata=the registered store data.
REQ-010 From IDLE, dmem_ready=1 in the issue cycle SHALL move the FSM to HOLD (zero wait states); dmem_ready=0 SHALL move it to WAIT.
REQ-011 In WAIT, dmem_req/we/addr/wdata SHALL remain asserted and stable from bus-side latches captured at issue, until dmem_ready=1, after which the FSM SHALL move to HOLD.
REQ-012 mem_busy_m SHALL equal dmem_req & !dmem_ready.
REQ-013 On the dmem_ready cycle of a load, dmem_rdata SHALL be captured into a read-data register; mem_rdata_m SHALL be dmem_rdata in that cycle and the captured value afterwards.
REQ-014 In HOLD, no new request SHALL issue, so stalls caused by other stages never re-issue a store; HOLD SHALL return to IDLE when the stage registers load (flush_m or !stall_m).
REQ-015 A flush_m asserted in WAIT SHALL clear the stage registers but the bus transaction SHALL complete; its read data SHALL be discarded and the FSM SHALL go to IDLE after dmem_ready.
REQ-016 Non-memory instructions SHALL pass through with dmem_req=0 and a 1-cycle stage latency.

Reset
REQ-017 rst_n low SHALL asynchronously zero all _m outputs, mem_rdata_m, bus latches, dmem_req, dmem_we and mem_busy_m, and force IDLE; reset asserted mid-WAIT SHALL abandon the access.

Configuration
REQ-018 With MEMORY_WAIT_EN defined, wait states SHALL be supported per REQ-010..015; without it, dmem_ready SHALL be ignored, every access SHALL complete in the issue cycle (IDLE->HOLD), WAIT SHALL not exist, and mem_busy_m SHALL be tied 0.

Verification
REQ-019 Store alu_res_e=0x100, mem_data_e=0xDEADBEEF, dmem_ready=1 -> one cycle of dmem_req=1, we=1, addr=0x100, wdata=0xDEADBEEF; mem_busy_m=0.
REQ-020 Load at 0x200 with dmem_ready after 3 cycles, rdata=0x12345678 -> mem_busy_m=1 for 3 cycles, addr stable, mem_rdata_m=0x12345678 thereafter.
REQ-021 Store completes, then stall_m held 4 cycles -> exactly one dmem_req pulse.
REQ-022 flush_m during WAIT of a load -> _m registers zero next cycle, dmem_req held until ready, mem_rdata_m not updated.
REQ-023 rst_n low mid-WAIT -> dmem_req=0 immediately, all outputs 0, FSM IDLE.
REQ-024 Build without MEMORY_WAIT_EN, dmem_ready=0, load -> access completes in 1 cycle, mem_busy_m=0.
